// File: rtl/pool_flatten_stage_pkg.sv
// Shared types and constants for the pool/flatten stage of the convolution pipeline.
package conv_pkg;

    localparam int IMG_W = 64;
    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int IDX_W = 2 * $clog2(IMG_W / 2);

    localparam logic [2:0] CSEL_NONE  = 3'b000;
    localparam logic [2:0] CSEL_L0_K0 = 3'b001;
    localparam logic [2:0] CSEL_L0_K1 = 3'b010;
    localparam logic [2:0] CSEL_L1_K0 = 3'b011;
    localparam logic [2:0] CSEL_L1_K1 = 3'b100;
    localparam logic [2:0] CSEL_L2    = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD0  = 3'd1,
        ST_RD1  = 3'd2,
        ST_RD2  = 3'd3,
        ST_RD3  = 3'd4,
        ST_WR1  = 3'd5,
        ST_WR2  = 3'd6,
        ST_DONE = 3'd7
    } pool_state_t;

endpackage

// File: rtl/pool_flatten_stage_if.sv
// Shared csel memory bus: one read port and one write port steered by csel.
interface pool_flatten_stage_if;
    import conv_pkg::*;

    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic [2:0]    csel;

    modport master (
        output crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        input  cdata_rd
    );

    modport slave (
        input  crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel,
        output cdata_rd
    );

endinterface

// File: rtl/pool_flatten_stage_addr_gen.sv
// Window/pixel/kernel counters and registered read/write address formation.
module pool_addr_gen
    import conv_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          rd_adv_i,
    input  logic          px_adv_i,
    input  logic          rd_en_i,
    input  logic          wr1_en_i,
    input  logic          wr2_en_i,
    output logic          last_o,
    output logic          k_o,
    output logic [AW-1:0] caddr_rd_o,
    output logic [AW-1:0] caddr_wr_o
);

    logic [1:0]       dydx_q, dydx_d;
    logic [IDX_W:0]   kidx_q, kidx_d;
    logic [AW-1:0]    caddr_rd_q, caddr_rd_d;
    logic [AW-1:0]    caddr_wr_q, caddr_wr_d;
    logic [IDX_W-1:0] idx_d;
    logic [4:0]       r_d, c_d;
    logic             k_d;

    // {k, idx} is one counter, so idx 1023 rolls into the next kernel and the final pixel wraps to zero
    always_comb begin
        dydx_d = dydx_q;
        kidx_d = kidx_q;
        if (clr_i) begin
            dydx_d = 2'd0;
            kidx_d = '0;
        end else begin
            if (rd_adv_i) begin
                dydx_d = dydx_q + 2'd1;
            end else begin
                dydx_d = dydx_q;
            end
            if (px_adv_i) begin
                kidx_d = kidx_q + {{IDX_W{1'b0}}, 1'b1};
            end else begin
                kidx_d = kidx_q;
            end
        end
    end

    // Addresses are built from next-cycle counter values so they register alongside the strobes
    always_comb begin
        k_d        = kidx_d[IDX_W];
        idx_d      = kidx_d[IDX_W-1:0];
        r_d        = idx_d[9:5];
        c_d        = idx_d[4:0];
        caddr_rd_d = '0;
        caddr_wr_d = '0;
        if (rd_en_i) begin
            caddr_rd_d = {r_d, dydx_d[1], c_d, dydx_d[0]};
        end else begin
            caddr_rd_d = '0;
        end
        if (wr1_en_i) begin
            caddr_wr_d = {2'b00, idx_d};
        end else if (wr2_en_i) begin
            caddr_wr_d = {1'b0, idx_d, k_d};
        end else begin
            caddr_wr_d = '0;
        end
    end

    // Counter and address registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dydx_q     <= 2'd0;
            kidx_q     <= '0;
            caddr_rd_q <= '0;
            caddr_wr_q <= '0;
        end else begin
            dydx_q     <= dydx_d;
            kidx_q     <= kidx_d;
            caddr_rd_q <= caddr_rd_d;
            caddr_wr_q <= caddr_wr_d;
        end
    end

    assign last_o     = &kidx_q;
    assign k_o        = kidx_d[IDX_W];
    assign caddr_rd_o = caddr_rd_q;
    assign caddr_wr_o = caddr_wr_q;

endmodule

// File: rtl/pool_flatten_stage.sv
// 2x2 max-pool of both layer-0 kernels into L1, with kernel-interleaved copy into L2.
module pool_flatten_stage
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    pool_flatten_stage_if.master  mem
);

    pool_state_t   state_q, state_d;
    logic [DW-1:0] max_q, max_d;
    logic [DW-1:0] cdata_wr_q, cdata_wr_d;
    logic [2:0]    csel_q, csel_d;
    logic          crd_q, crd_d, cwr_q, cwr_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic          rd_nxt, wr1_nxt, wr2_nxt;
    logic          last, k_nxt;

    pool_addr_gen u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (reset),
        .clr_i      ((state_q == ST_IDLE) || (state_q == ST_DONE)),
        .rd_adv_i   (state_q inside {ST_RD0, ST_RD1, ST_RD2, ST_RD3}),
        .px_adv_i   (state_q == ST_WR2),
        .rd_en_i    (rd_nxt),
        .wr1_en_i   (wr1_nxt),
        .wr2_en_i   (wr2_nxt),
        .last_o     (last),
        .k_o        (k_nxt),
        .caddr_rd_o (mem.caddr_rd),
        .caddr_wr_o (mem.caddr_wr)
    );

    // Sequencer next state; start is only honoured from IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RD0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD0:  state_d = ST_RD1;
            ST_RD1:  state_d = ST_RD2;
            ST_RD2:  state_d = ST_RD3;
            ST_RD3:  state_d = ST_WR1;
            ST_WR1:  state_d = ST_WR2;
            ST_WR2: begin
                if (last) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RD0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Running window maximum; strict compare keeps the earlier value on a tie
    always_comb begin
        max_d = max_q;
        case (state_q)
            ST_RD0: max_d = mem.cdata_rd;
            ST_RD1, ST_RD2, ST_RD3: begin
                if (mem.cdata_rd > max_q) begin
                    max_d = mem.cdata_rd;
                end else begin
                    max_d = max_q;
                end
            end
            default: max_d = max_q;
        endcase
    end

    // Output values for the state being entered, so every port comes straight from a flop
    always_comb begin
        rd_nxt     = state_d inside {ST_RD0, ST_RD1, ST_RD2, ST_RD3};
        wr1_nxt    = (state_d == ST_WR1);
        wr2_nxt    = (state_d == ST_WR2);
        crd_d      = rd_nxt;
        cwr_d      = wr1_nxt || wr2_nxt;
        busy_d     = !((state_d == ST_IDLE) || (state_d == ST_DONE));
        done_d     = (state_d == ST_DONE);
        cdata_wr_d = '0;
        csel_d     = CSEL_NONE;
        if (rd_nxt) begin
            csel_d = k_nxt ? CSEL_L0_K1 : CSEL_L0_K0;
        end else if (wr1_nxt) begin
            csel_d = k_nxt ? CSEL_L1_K1 : CSEL_L1_K0;
        end else if (wr2_nxt) begin
            csel_d = CSEL_L2;
        end else begin
            csel_d = CSEL_NONE;
        end
        if (cwr_d) begin
            cdata_wr_d = max_d;
        end else begin
            cdata_wr_d = '0;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            max_q      <= '0;
            cdata_wr_q <= '0;
            csel_q     <= CSEL_NONE;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            max_q      <= max_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
            crd_q      <= crd_d;
            cwr_q      <= cwr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem.crd      = crd_q;
    assign mem.cwr      = cwr_q;
    assign mem.csel     = csel_q;
    assign mem.cdata_wr = cdata_wr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pool_flatten_stage.sv
// Self-checking bench: memory models on the csel bus, bus monitor, window vector table.
module tb_pool_flatten_stage;
    import conv_pkg::*;

    localparam int            PASS_CYC = 12288;
    localparam logic [DW-1:0] SENT     = 20'h5A5A5;

    typedef struct {
        int            k;
        int            idx;
        logic [DW-1:0] w0, w1, w2, w3;
        logic [DW-1:0] ex;
    } vec_t;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic start   = 1'b0;
    logic clr_req = 1'b0;
    logic busy, done;

    logic [DW-1:0] l0k0 [4096];
    logic [DW-1:0] l0k1 [4096];
    logic [DW-1:0] l1k0 [1024];
    logic [DW-1:0] l1k1 [1024];
    logic [DW-1:0] l2m  [2048];

    int   checks = 0;
    int   failures = 0;
    int   n_rd = 0;
    int   n_wr = 0;
    int   n_bad = 0;
    logic mon_bad;
    vec_t vecs [12];

    pool_flatten_stage_if bus ();

    pool_flatten_stage dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .mem   (bus)
    );

    always #5 clk = ~clk;

    // Read side of the memory models: data valid within the crd cycle
    always_comb begin
        bus.cdata_rd = '0;
        if (bus.crd) begin
            case (bus.csel)
                CSEL_L0_K0: bus.cdata_rd = l0k0[bus.caddr_rd];
                CSEL_L0_K1: bus.cdata_rd = l0k1[bus.caddr_rd];
                default:    bus.cdata_rd = '0;
            endcase
        end
    end

    // Write side of the memory models, plus a bench-requested fill with a sentinel
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < 2048; i++) begin
                l2m[i] <= SENT;
                if (i < 1024) begin
                    l1k0[i] <= SENT;
                    l1k1[i] <= SENT;
                end
            end
        end else if (bus.cwr) begin
            case (bus.csel)
                CSEL_L1_K0: l1k0[bus.caddr_wr[9:0]] <= bus.cdata_wr;
                CSEL_L1_K1: l1k1[bus.caddr_wr[9:0]] <= bus.cdata_wr;
                CSEL_L2:    l2m[bus.caddr_wr[10:0]] <= bus.cdata_wr;
                default:    ;
            endcase
        end
    end

    assign mon_bad = (bus.crd && bus.cwr)
        || (bus.crd && (bus.csel != CSEL_L0_K0) && (bus.csel != CSEL_L0_K1))
        || (bus.cwr && !(bus.csel inside {CSEL_L1_K0, CSEL_L1_K1, CSEL_L2}))
        || (bus.cwr && (bus.csel != CSEL_L2) && (bus.caddr_wr[11:10] != 2'b00))
        || (bus.cwr && bus.caddr_wr[11])
        || (!bus.crd && !bus.cwr &&
            ((bus.csel != 3'b000) || (bus.caddr_rd != '0) || (bus.caddr_wr != '0)));

    // Bus protocol monitor
    always @(negedge clk) begin
        if (bus.crd) n_rd <= n_rd + 1;
        if (bus.cwr) n_wr <= n_wr + 1;
        if (mon_bad) n_bad <= n_bad + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int waddr(input int idx, input int p);
        return ((idx / 32) * 2 + p / 2) * IMG_W + (idx % 32) * 2 + p % 2;
    endfunction

    function automatic logic [DW-1:0] win_max(input int k, input int idx);
        logic [DW-1:0] m, v;
        m = '0;
        for (int p = 0; p < 4; p++) begin
            v = (k == 0) ? l0k0[waddr(idx, p)] : l0k1[waddr(idx, p)];
            if (p == 0 || v > m) m = v;
        end
        return m;
    endfunction

    task automatic chk_quiet(input string tag);
        check({tag, " busy/done/crd/cwr"}, {28'd0, busy, done, bus.crd, bus.cwr}, 32'd0);
        check({tag, " csel"}, {29'd0, bus.csel}, 32'd0);
        check({tag, " addrs"}, {8'd0, bus.caddr_rd, bus.caddr_wr}, 32'd0);
        check({tag, " wdata"}, {12'd0, bus.cdata_wr}, 32'd0);
    endtask

    task automatic fill_sentinel();
        @(negedge clk) clr_req = 1'b1;
        @(negedge clk) clr_req = 1'b0;
    endtask

    task automatic sweep(input string tag);
        int b0, b1, b2;
        b0 = 0; b1 = 0; b2 = 0;
        for (int i = 0; i < 1024; i++) begin
            if (l1k0[i] !== win_max(0, i)) b0++;
            if (l1k1[i] !== win_max(1, i)) b1++;
            if (l2m[2 * i] !== win_max(0, i)) b2++;
            if (l2m[2 * i + 1] !== win_max(1, i)) b2++;
        end
        check({tag, " L1_K0 wrong words"}, b0, 0);
        check({tag, " L1_K1 wrong words"}, b1, 0);
        check({tag, " L2 wrong words"}, b2, 0);
    endtask

    // Full pass: start pulse, optional stray start mid-pass, latency/busy/bus counts, start-on-done
    task automatic run_pass(input string tag, input int restart_at);
        int cyc, gap, rd0, wr0, bad0;
        bit got;
        cyc = 0; gap = 0; got = 1'b0;
        @(negedge clk);
        rd0 = n_rd; wr0 = n_wr; bad0 = n_bad;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " busy after start"}, {31'd0, busy}, 32'd1);
        while (!got && cyc < PASS_CYC + 500) begin
            @(posedge clk);
            cyc++;
            #1;
            start = (restart_at != 0 && cyc == restart_at) ? 1'b1 : 1'b0;
            if (done) got = 1'b1;
            else if (!busy) gap++;
        end
        check({tag, " done latency"}, cyc, PASS_CYC);
        check({tag, " busy low with done"}, {31'd0, busy}, 32'd0);
        check({tag, " busy gaps"}, gap, 0);
        check({tag, " read count"}, n_rd - rd0, 8192);
        check({tag, " write count"}, n_wr - wr0, 4096);
        check({tag, " protocol violations"}, n_bad - bad0, 0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
        check({tag, " start on done ignored"}, {30'd0, busy, bus.crd}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{0, 0,    20'd5,       20'd9,       20'd9,       20'd3, 20'd9};
        vecs[1]  = '{0, 33,   20'd3,       20'd5,       20'd9,       20'd9, 20'd9};
        vecs[2]  = '{0, 66,   20'd9,       20'd3,       20'd5,       20'd9, 20'd9};
        vecs[3]  = '{0, 99,   20'd9,       20'd9,       20'd3,       20'd5, 20'd9};
        vecs[4]  = '{0, 200,  20'd7,       20'd7,       20'd7,       20'd7, 20'd7};
        vecs[5]  = '{0, 5,    20'h12345,   20'd0,       20'd0,       20'h12344, 20'h12345};
        vecs[6]  = '{1, 5,    20'd0,       20'h0ABCD,   20'h0ABCC,   20'd1, 20'h0ABCD};
        vecs[7]  = '{0, 300,  20'h7FFFF,   20'h80000,   20'd0,       20'd0, 20'h80000};
        vecs[8]  = '{1, 992,  20'd1,       20'd2,       20'd3,       20'd4, 20'd4};
        vecs[9]  = '{0, 1023, 20'd4,       20'd3,       20'd2,       20'd1, 20'd4};
        vecs[10] = '{1, 1023, 20'd0,       20'd0,       20'hFFFFF,   20'd0, 20'hFFFFF};
        vecs[11] = '{1, 31,   20'd0,       20'd0,       20'd0,       20'd0, 20'd0};

        for (int a = 0; a < 4096; a++) begin
            l0k0[a] = DW'(a);
            l0k1[a] = ~DW'(a);
        end

        #3;
        chk_quiet("in reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_quiet("idle after reset");

        // Ramp pattern, with a stray start 100 cycles in
        fill_sentinel();
        run_pass("ramp", 100);
        check("ramp L1_K0[0]", {12'd0, l1k0[0]}, 32'h00041);
        check("ramp L1_K0[1023]", {12'd0, l1k0[1023]}, 32'h00FFF);
        check("ramp L1_K1[1023]", {12'd0, l1k1[1023]}, 32'hFF041);
        check("ramp L2[0]", {12'd0, l2m[0]}, 32'h00041);
        check("ramp L2[2047]", {12'd0, l2m[2047]}, 32'hFF041);
        sweep("ramp");

        // Hand-built windows overlaid on the ramp
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].k == 0) begin
                l0k0[waddr(vecs[v].idx, 0)] = vecs[v].w0;
                l0k0[waddr(vecs[v].idx, 1)] = vecs[v].w1;
                l0k0[waddr(vecs[v].idx, 2)] = vecs[v].w2;
                l0k0[waddr(vecs[v].idx, 3)] = vecs[v].w3;
            end else begin
                l0k1[waddr(vecs[v].idx, 0)] = vecs[v].w0;
                l0k1[waddr(vecs[v].idx, 1)] = vecs[v].w1;
                l0k1[waddr(vecs[v].idx, 2)] = vecs[v].w2;
                l0k1[waddr(vecs[v].idx, 3)] = vecs[v].w3;
            end
        end
        fill_sentinel();
        run_pass("vec", 0);
        for (int v = 0; v < 12; v++) begin
            check($sformatf("vec%0d L1 k%0d idx%0d", v, vecs[v].k, vecs[v].idx),
                  {12'd0, (vecs[v].k == 0) ? l1k0[vecs[v].idx] : l1k1[vecs[v].idx]},
                  {12'd0, vecs[v].ex});
            check($sformatf("vec%0d L2[%0d]", v, 2 * vecs[v].idx + vecs[v].k),
                  {12'd0, l2m[2 * vecs[v].idx + vecs[v].k]}, {12'd0, vecs[v].ex});
        end
        check("interleave L2[10]", {12'd0, l2m[10]}, 32'h12345);
        check("interleave L2[11]", {12'd0, l2m[11]}, 32'h0ABCD);
        sweep("vec");

        // Reset in the middle of a pass, then a clean pass
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4999) @(posedge clk);
        #2;
        check("pass active before reset", {31'd0, bus.crd | bus.cwr}, 32'd1);
        reset = 1'b0;
        #1 chk_quiet("async reset");
        repeat (3) @(negedge clk);
        chk_quiet("held reset");
        reset = 1'b1;
        @(posedge clk);
        #1 check("no restart after reset", {31'd0, busy}, 32'd0);
        fill_sentinel();
        run_pass("post-reset", 0);
        sweep("post-reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
